// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared state encoding and constants for the restoring divider
package div_pkg;
    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_e;

    // Quotient reported on divide-by-zero; sliced down to the operand width at use.
    localparam logic [63:0] DBZ_ALL_ONES = '1;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - request/result bundle between the ALU and the divide path
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// rtl/seq_restoring_divider_step.sv - one combinational restoring step: trial subtract, keep or restore
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   t_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_o
);
    logic [WIDTH:0] diff;

    assign diff = t_i - {1'b0, divisor_i};
    assign q_o  = ~diff[WIDTH];
    // Partial remainder stays below the divisor, so WIDTH bits always hold it.
    assign r_o  = diff[WIDTH] ? t_i[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's complement operands
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_r, q_next;
    logic             step_q;

`ifdef DIV_SIGNED_EN
    assign a_neg = bus.dividend[WIDTH-1];
    assign b_neg = bus.divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif

    // The most negative value's magnitude still fits as an unsigned WIDTH-bit number.
    assign a_mag = a_neg ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
    assign b_mag = b_neg ? ({WIDTH{1'b0}} - bus.divisor)  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .t_i       ({r_q, q_q[WIDTH-1]}),
        .divisor_i (div_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    assign q_next = {q_q[WIDTH-2:0], step_q};
    assign accept = bus.start && (state_q != RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        div_d      = div_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        case (state_q)
            RUN: begin
                r_d = step_r;
                q_d = q_next;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = neg_quot_q ? ({WIDTH{1'b0}} - q_next) : q_next;
                    rem_d   = neg_rem_q  ? ({WIDTH{1'b0}} - step_r) : step_r;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // A start seen in DONE chains straight into the next operation.
        if (accept) begin
            r_d        = '0;
            q_d        = a_mag;
            div_d      = b_mag;
            cnt_d      = CNT_W'(WIDTH - 1);
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            dbz_d      = 1'b0;
            if (bus.divisor == '0) begin
                state_d = DONE;
                dbz_d   = 1'b1;
                quot_d  = DBZ_ALL_ONES[WIDTH-1:0];
                rem_d   = bus.dividend;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            div_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            div_q      <= div_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - table-driven scoreboard bench for seq_restoring_divider
module tb_seq_restoring_divider;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[$];

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t vt(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
        return v;
    endfunction

    // Reference result from the language's own division operators.
    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int   sa;
        int   sd;
        v.a = a; v.b = b; v.dbz = (b == '0);
        if (b == '0) begin
            v.q = '1;
            v.r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa  = $signed(a);
            sd  = $signed(b);
            v.q = W'(sa / sd);
            v.r = W'(sa % sd);
`else
            sa  = int'(a);
            sd  = int'(b);
            v.q = W'(sa / sd);
            v.r = W'(sa % sd);
`endif
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_quotient"}, int'(bus.quotient), int'(e.q));
        check({tag, "_remainder"}, int'(bus.remainder), int'(e.r));
        check({tag, "_div_by_zero"}, int'(bus.div_by_zero), int'(e.dbz));
    endtask

    // Entered on a negedge after the accept edge; lat0 counts negedges already seen.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat;
        lat = lat0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        pop_compare(tag);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = v.a; bus.divisor = v.b;
        sb.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, int'(bus.busy), v.dbz ? 0 : 1);
        wait_done(tag, 1, v.dbz ? 1 : W + 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(bus.done), 0);
        check({tag, "_held_quotient"}, int'(bus.quotient), int'(v.q));
    endtask

    initial begin
        vec_t first;
        int   seen;

`ifdef DIV_SIGNED_EN
        tbl.push_back(vt(4'd9,  4'd2,  4'd13, 4'd15, 1'b0));
        tbl.push_back(vt(4'd8,  4'd15, 4'd8,  4'd0,  1'b0));
        tbl.push_back(vt(4'd7,  4'd14, 4'd13, 4'd1,  1'b0));
        tbl.push_back(vt(4'd10, 4'd13, 4'd2,  4'd0,  1'b0));
        tbl.push_back(vt(4'd5,  4'd0,  4'd15, 4'd5,  1'b1));
        tbl.push_back(vt(4'd8,  4'd3,  4'd14, 4'd14, 1'b0));
        tbl.push_back(vt(4'd3,  4'd4,  4'd0,  4'd3,  1'b0));
`else
        tbl.push_back(vt(4'd13, 4'd3,  4'd4,  4'd1,  1'b0));
        tbl.push_back(vt(4'd7,  4'd0,  4'd15, 4'd7,  1'b1));
        tbl.push_back(vt(4'd15, 4'd1,  4'd15, 4'd0,  1'b0));
        tbl.push_back(vt(4'd9,  4'd2,  4'd4,  4'd1,  1'b0));
        tbl.push_back(vt(4'd14, 4'd5,  4'd2,  4'd4,  1'b0));
        tbl.push_back(vt(4'd0,  4'd5,  4'd0,  4'd0,  1'b0));
        tbl.push_back(vt(4'd15, 4'd15, 4'd1,  4'd0,  1'b0));
        tbl.push_back(vt(4'd3,  4'd7,  4'd0,  4'd3,  1'b0));
        tbl.push_back(vt(4'd8,  4'd3,  4'd2,  4'd2,  1'b0));
        tbl.push_back(vt(4'd0,  4'd0,  4'd15, 4'd0,  1'b1));
        tbl.push_back(vt(4'd1,  4'd1,  4'd1,  4'd0,  1'b0));
        tbl.push_back(vt(4'd15, 4'd2,  4'd7,  4'd1,  1'b0));
`endif

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;

        // Reset held with start asserted: reset must win.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_quotient", int'(bus.quotient), 0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_div_by_zero", int'(bus.div_by_zero), 0);
        bus.start = 1'b0;
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // A start pulsed mid-run is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd1;
        sb.push_back(mk(4'd15, 4'd1));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore_mid_run", 3, W + 1);
        @(negedge clk);
        check("ignore_mid_run_idle", int'(bus.busy), 0);

        // Back-to-back: start held in the done cycle chains a new operation.
        @(negedge clk);
        first = mk(4'd9, 4'd2);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        sb.push_back(first);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_first", 1, W + 1);
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd5;
        sb.push_back(mk(4'd14, 4'd5));
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_done_drop", int'(bus.done), 0);
        check("b2b_busy", int'(bus.busy), 1);
        check("b2b_held_quotient", int'(bus.quotient), int'(first.q));
        check("b2b_held_remainder", int'(bus.remainder), int'(first.r));
        wait_done("b2b_second", 1, W + 1);

        // Reset in the second run cycle discards the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_quotient", int'(bus.quotient), 0);
        check("midrst_remainder", int'(bus.remainder), 0);
        check("midrst_div_by_zero", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        check("midrst_no_done", seen, 0);

        run_vec(mk(4'd13, 4'd3), "post_reset");

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
